// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter
//   Owns the frame buffer write port and shares it between a host pixel
//   stream (valid/ready) and a rectangle-fill engine. In tear-free mode,
//   writes are only issued while blank is high. Row addresses are built by
//   repeated addition of fb_width, so no multiplier is needed.
//
// Ports
//   clk, srst               clock, asynchronous active-high reset
//   fb_width                row stride used by the fill engine
//   tear_free, blank        write gating (allow = !tear_free || blank)
//   host_valid/ready/pos/pixel  host pixel stream
//   fill_start/x/y/w/h/color    fill command
//   fill_busy, fill_done    fill engine status (done is a 1-cycle pulse)
//   wr_en, write_pos, pixel registered frame buffer write port
module vga_write_arbiter #(
    parameter int BUF_WIDTH  = 640,
    parameter int BUF_HEIGHT = 480,
    parameter int BUF_PIXELS = BUF_WIDTH * BUF_HEIGHT
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [9:0]  fb_width,
    input  logic        tear_free,
    input  logic        blank,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [20:0] host_pos,
    input  logic [2:0]  host_pixel,
    input  logic        fill_start,
    input  logic [9:0]  fill_x,
    input  logic [9:0]  fill_y,
    input  logic [10:0] fill_w,
    input  logic [10:0] fill_h,
    input  logic [2:0]  fill_color,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        wr_en,
    output logic [20:0] write_pos,
    output logic [2:0]  pixel
);

    localparam logic [20:0] LIMIT = 21'(BUF_PIXELS);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_FILL, ST_DONE} state_t;
    typedef enum logic {LG_HOST, LG_FILL} grant_t;

    state_t      state_q;
    grant_t      last_grant_q;
    logic [9:0]  x_q;
    logic [10:0] w_q;
    logic [10:0] h_q;
    logic [2:0]  color_q;
    logic [20:0] row_base_q;
    logic [9:0]  cnt_q;
    logic [10:0] col_q;
    logic [10:0] row_q;
    logic        fill_busy_q;
    logic        fill_done_q;
    logic        wr_en_q;
    logic [20:0] write_pos_q;
    logic [2:0]  pixel_q;

    logic        allow;
    logic        host_req;
    logic        fill_req;
    logic        grant_host;
    logic        grant_fill;
    logic [20:0] fill_addr;
    logic [20:0] grant_addr;
    logic [2:0]  grant_pixel;
    logic [20:0] stride;

    assign stride = {11'd0, fb_width};

    always_comb begin
        allow      = !tear_free || blank;
        // host_ready must read 0 while reset is held, hence the srst term
        host_req   = host_valid && allow && !srst;
        fill_req   = (state_q == ST_FILL) && allow;
        // on a tie the requester that did not win last time is served
        grant_host = host_req && (!fill_req || (last_grant_q == LG_FILL));
        grant_fill = fill_req && !grant_host;
        fill_addr  = row_base_q + {11'd0, x_q} + {10'd0, col_q};
        grant_addr = grant_host ? host_pos : fill_addr;
        grant_pixel = grant_host ? host_pixel : color_q;
    end

    assign host_ready = grant_host;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LG_FILL;
            x_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            color_q      <= '0;
            row_base_q   <= '0;
            cnt_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            write_pos_q  <= '0;
            pixel_q      <= '0;
        end else begin
            fill_done_q <= 1'b0;
            wr_en_q     <= 1'b0;

            if (grant_host) last_grant_q <= LG_HOST;
            if (grant_fill) last_grant_q <= LG_FILL;

            // out-of-range grants still count (ack / advance) but never write
            if ((grant_host || grant_fill) && (grant_addr < LIMIT)) begin
                wr_en_q     <= 1'b1;
                write_pos_q <= grant_addr;
                pixel_q     <= grant_pixel;
            end

            case (state_q)
                ST_IDLE: begin
                    if (fill_start) begin
                        x_q         <= fill_x;
                        w_q         <= fill_w;
                        h_q         <= fill_h;
                        color_q     <= fill_color;
                        fill_busy_q <= 1'b1;
                        if ((fill_w == 11'd0) || (fill_h == 11'd0)) begin
                            state_q <= ST_DONE;
                        end else begin
                            row_base_q <= '0;
                            cnt_q      <= fill_y;
                            state_q    <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    // row_base = fill_y * fb_width, one addition per cycle
                    if (cnt_q == 10'd0) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= ST_FILL;
                    end else begin
                        row_base_q <= row_base_q + stride;
                        cnt_q      <= cnt_q - 10'd1;
                    end
                end
                ST_FILL: begin
                    if (grant_fill) begin
                        if (col_q == w_q - 11'd1) begin
                            col_q      <= '0;
                            row_q      <= row_q + 11'd1;
                            row_base_q <= row_base_q + stride;
                            if (row_q == h_q - 11'd1) state_q <= ST_DONE;
                        end else begin
                            col_q <= col_q + 11'd1;
                        end
                    end
                end
                ST_DONE: begin
                    fill_done_q <= 1'b1;
                    fill_busy_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fill_busy = fill_busy_q;
    assign fill_done = fill_done_q;
    assign wr_en     = wr_en_q;
    assign write_pos = write_pos_q;
    assign pixel     = pixel_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
module tb_vga_write_arbiter;

    logic        clk = 1'b0;
    logic        srst;
    logic [9:0]  fb_width;
    logic        tear_free;
    logic        blank;
    logic        host_valid;
    logic        host_ready;
    logic [20:0] host_pos;
    logic [2:0]  host_pixel;
    logic        fill_start;
    logic [9:0]  fill_x;
    logic [9:0]  fill_y;
    logic [10:0] fill_w;
    logic [10:0] fill_h;
    logic [2:0]  fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic        wr_en;
    logic [20:0] write_pos;
    logic [2:0]  pixel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_write_arbiter dut (
        .clk(clk), .srst(srst), .fb_width(fb_width), .tear_free(tear_free),
        .blank(blank), .host_valid(host_valid), .host_ready(host_ready),
        .host_pos(host_pos), .host_pixel(host_pixel), .fill_start(fill_start),
        .fill_x(fill_x), .fill_y(fill_y), .fill_w(fill_w), .fill_h(fill_h),
        .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
        .wr_en(wr_en), .write_pos(write_pos), .pixel(pixel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic start_fill(input logic [9:0] x, input logic [9:0] y,
                              input logic [10:0] w, input logic [10:0] h,
                              input logic [2:0] c);
        @(negedge clk);
        fill_x = x; fill_y = y; fill_w = w; fill_h = h; fill_color = c;
        fill_start = 1'b1;
        @(posedge clk);
        #1 fill_start = 1'b0;
    endtask

    typedef struct {
        logic        tf;
        logic        blank;
        logic        valid;
        logic [20:0] pos;
        logic [2:0]  pix;
        logic        exp_ready;
        logic        exp_wr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          nwr;
        int          first_edge;
        int          done_cnt;
        int          done_edge;
        int          bad;
        logic [20:0] wr_addr[8];
        logic [2:0]  wr_pix[8];
        logic [20:0] hpos;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 21'd5,       3'd1, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 21'd100,     3'd4, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 21'd100,     3'd4, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 21'd200,     3'd3, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 21'd307200,  3'd6, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 21'd307199,  3'd6, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 21'd2097151, 3'd2, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 21'd0,       3'd7, 1'b1, 1'b1};

        srst = 1'b1; fb_width = 10'd640; tear_free = 1'b0; blank = 1'b0;
        host_valid = 1'b0; host_pos = '0; host_pixel = '0;
        fill_start = 1'b0; fill_x = '0; fill_y = '0; fill_w = '0; fill_h = '0;
        fill_color = '0;

        // reset state
        #1;
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_write_pos", 32'(write_pos), 0);
        check("rst_pixel", 32'(pixel), 0);
        check("rst_busy", 32'(fill_busy), 0);
        check("rst_done", 32'(fill_done), 0);
        check("rst_host_ready", 32'(host_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) srst = 1'b0;

        // basic fill: x=2 y=3 w=2 h=2 color=5
        start_fill(10'd2, 10'd3, 11'd2, 11'd2, 3'd5);
        check("fill_busy_after_start", 32'(fill_busy), 1);
        nwr = 0; first_edge = -1; done_cnt = 0; done_edge = -1;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk); #1;
            if (wr_en) begin
                if (first_edge < 0) first_edge = e;
                if (nwr < 8) begin
                    wr_addr[nwr] = write_pos;
                    wr_pix[nwr]  = pixel;
                end
                nwr++;
            end
            if (fill_done) begin
                done_cnt++;
                done_edge = e;
                check("busy_low_with_done", 32'(fill_busy), 0);
            end
        end
        check("fill_nwrites", 32'(nwr), 4);
        check("fill_first_write_edge", 32'(first_edge), 5);
        check("fill_addr0", 32'(wr_addr[0]), 1922);
        check("fill_addr1", 32'(wr_addr[1]), 1923);
        check("fill_addr2", 32'(wr_addr[2]), 2562);
        check("fill_addr3", 32'(wr_addr[3]), 2563);
        check("fill_pix0", 32'(wr_pix[0]), 5);
        check("fill_pix3", 32'(wr_pix[3]), 5);
        check("fill_done_count", 32'(done_cnt), 1);
        check("fill_done_edge", 32'(done_edge), 9);

        // zero-width fill: done two cycles after start, never writes
        start_fill(10'd0, 10'd0, 11'd0, 11'd7, 3'd1);
        check("w0_done_edge0", 32'(fill_done), 0);
        check("w0_wr_edge0", 32'(wr_en), 0);
        @(posedge clk); #1;
        check("w0_done_edge1", 32'(fill_done), 1);
        check("w0_busy_edge1", 32'(fill_busy), 0);
        check("w0_wr_edge1", 32'(wr_en), 0);
        @(posedge clk); #1;
        check("w0_done_edge2", 32'(fill_done), 0);

        // contended: host streaming during a 4-pixel fill, host first
        start_fill(10'd0, 10'd0, 11'd4, 11'd1, 3'd2);
        @(posedge clk); #1;
        hpos = 21'd1000;
        host_valid = 1'b1; host_pos = hpos; host_pixel = 3'd7;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rr_ready_%0d", i), 32'(host_ready), 32'(i % 2 == 0));
            @(posedge clk); #1;
            check($sformatf("rr_wr_%0d", i), 32'(wr_en), 1);
            if (i % 2 == 0) begin
                check($sformatf("rr_pos_%0d", i), 32'(write_pos), 32'(hpos));
                check($sformatf("rr_pix_%0d", i), 32'(pixel), 7);
                hpos = hpos + 21'd1;
                host_pos = hpos;
            end else begin
                check($sformatf("rr_pos_%0d", i), 32'(write_pos), 32'((i - 1) / 2));
                check($sformatf("rr_pix_%0d", i), 32'(pixel), 2);
            end
        end
        host_valid = 1'b0;
        @(posedge clk); #1;
        check("rr_fill_done", 32'(fill_done), 1);

        // table: host beats under tear-free gating and the address limit
        foreach (vecs[k]) begin
            @(negedge clk);
            tear_free = vecs[k].tf; blank = vecs[k].blank;
            host_valid = vecs[k].valid; host_pos = vecs[k].pos;
            host_pixel = vecs[k].pix;
            #1;
            check($sformatf("vec%0d_ready", k), 32'(host_ready), 32'(vecs[k].exp_ready));
            @(posedge clk); #1;
            check($sformatf("vec%0d_wr_en", k), 32'(wr_en), 32'(vecs[k].exp_wr));
            if (vecs[k].exp_wr) begin
                check($sformatf("vec%0d_pos", k), 32'(write_pos), 32'(vecs[k].pos));
                check($sformatf("vec%0d_pix", k), 32'(pixel), 32'(vecs[k].pix));
            end
        end
        @(negedge clk);
        host_valid = 1'b0; tear_free = 1'b0; blank = 1'b0;

        // asynchronous reset in the middle of a fill
        start_fill(10'd0, 10'd0, 11'd4, 11'd4, 3'd3);
        repeat (3) @(posedge clk);
        #1;
        check("mid_fill_wr_en", 32'(wr_en), 1);
        #2 srst = 1'b1;
        #1;
        check("async_rst_wr_en", 32'(wr_en), 0);
        check("async_rst_busy", 32'(fill_busy), 0);
        check("async_rst_done", 32'(fill_done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) srst = 1'b0;
        bad = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (wr_en || fill_busy || fill_done) bad++;
        end
        check("post_rst_activity", 32'(bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Sole owner of the vga frame buffer write port (write_pos, wr_en, pixel) in the clk domain.
- Shares that port between two requesters:
  - a host pixel stream using a valid/ready handshake;
  - an internal rectangle-fill engine used for clears and box draws.
- Optional tear-free mode only lets writes through during blanking.
- Computes row addresses by repeated addition, so the block contains no multiplier.

Parameters:
- BUF_WIDTH, 640, frame buffer width in pixels.
- BUF_HEIGHT, 480, frame buffer height in pixels.
- BUF_PIXELS, BUF_WIDTH*BUF_HEIGHT, number of valid write addresses. Any write to an address >= BUF_PIXELS is dropped.

Ports:
- clk  in  1  system clock; same clock as the vga write port.
- srst  in  1  asynchronous, active-high reset.
- fb_width  in  10  active line width in pixels; row stride for fills.
- tear_free  in  1  1 = writes are issued only while blank=1.
- blank  in  1  non-visible indication, already synchronised to clk by the instantiating level.
- host_valid  in  1  host pixel request.
- host_ready  out  1  host request accepted this cycle.
- host_pos  in  21  host linear pixel address.
- host_pixel  in  3  host pixel colour.
- fill_start  in  1  single-cycle pulse that starts a fill.
- fill_x  in  10  fill rectangle left column.
- fill_y  in  10  fill rectangle top row.
- fill_w  in  11  fill width in pixels, 0..1024.
- fill_h  in  11  fill height in rows, 0..1024.
- fill_color  in  3  fill colour.
- fill_busy  out  1  fill engine not idle.
- fill_done  out  1  one-cycle pulse when a fill completes.
- wr_en  out  1  to vga wr_en.
- write_pos  out  21  to vga write_pos.
- pixel  out  3  to vga pixel.

Behaviour:
- Reset (async assert, release on clk):
  - wr_en=0, write_pos=0, pixel=0.
  - fill_busy=0, fill_done=0, host_ready=0.
  - FSM=IDLE, last_grant=FILL (host wins the first tie).
- All outputs except host_ready are registered. host_ready is combinational from registered state and current inputs.
- Write allowance: allow = !tear_free || blank.
- Fill FSM states:
  - IDLE:
    - On fill_start, latch x, y, w, h and colour, and set fill_busy=1.
    - If w==0 or h==0, go to DONE; otherwise clear row_base, set cnt=fill_y and go to SETUP.
    - fill_start while not IDLE is ignored and has no effect on the fill in progress.
  - SETUP:
    - Each cycle: if cnt==0, go to FILL with col=0 and row=0; else row_base += fb_width and cnt -= 1.
    - Latency is fill_y+1 cycles. fb_width is sampled every cycle and must be held stable during a fill.
    - Accumulators are 21 bits wide and wrap modulo 2^21.
  - FILL:
    - A fill request is presented when allow=1.
    - On grant, address = row_base + x + col, then col += 1.
    - When col==w-1 on a grant: col=0, row += 1, row_base += fb_width.
    - On the grant where row==h-1 and col==w-1, go to DONE.
  - DONE:
    - Assert fill_done=1 for one cycle, drop fill_busy in the same cycle, and return to IDLE.
- Arbitration (evaluated each cycle):
  - A host request exists when host_valid=1 and allow=1.
  - A fill request exists when state==FILL and allow=1.
  - With a single requester, that requester is granted.
  - With both requesting, the requester not equal to last_grant is granted (round-robin). last_grant updates on every grant.
  - host_ready=1 exactly when the host is granted. Host data transfers on host_valid && host_ready.
- Write issue:
  - The cycle after any grant: wr_en=1 with write_pos and pixel from the granted source.
  - If the granted address is >= BUF_PIXELS, wr_en stays 0 but the grant still counts. The host is still acked and the fill still advances.
  - With no grant, wr_en=0. write_pos and pixel hold their previous values.
- tear_free toggling mid-fill only pauses or resumes the fill; no state is lost.
- Reset mid-fill aborts immediately: no fill_done pulse and no further writes.
- Throughput: one write per cycle in total. An uncontended fill of w*h pixels takes fill_y+1 + w*h + 1 cycles from start to done.

Test Plan:
- Reset asserted mid-fill asynchronously (no clk edge) -> wr_en, fill_busy and fill_done fall to 0 immediately; after release, FSM is IDLE and no writes occur.
- fb_width=640, fill x=2, y=3, w=2, h=2, color=5, tear_free=0, no host -> after 4 SETUP cycles, writes to 1922, 1923, 2562, 2563 with pixel 5; fill_done pulses once and fill_busy drops in the same cycle.
- Fill w=0, h=7 -> fill_done pulses 2 cycles after start, with no wr_en at any point.
- Host streaming continuously during a 4-pixel fill -> grants alternate host, fill, host, fill, starting with the host; host_ready is 1 on alternate cycles and all 4 fill writes plus each accepted host write appear exactly once.
- tear_free=1, blank=0, host_valid=1 with pos 100 -> host_ready=0 and wr_en=0; blank rises -> wr_en=1, write_pos=100 one cycle later.
- host_pos=307200 (equal to BUF_PIXELS) -> host_ready=1 but wr_en stays 0; next beat at 307199 -> wr_en=1.
